// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command-to-APB master bridge with PREADY timeout
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SAT = {CW{1'b1}};
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      psel_q <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q <= '0;
      pwdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      pwrite_q <= pwrite_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q <= rsp_err_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    psel_d = psel_q;
    penable_d = penable_q;
    pwrite_d = pwrite_q;
    paddr_d = paddr_q;
    pwdata_d = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d = rsp_err_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = SETUP;
        psel_d = 1'b1;
        pwrite_d = cmd_write;
        paddr_d = cmd_addr;
        pwdata_d = cmd_wdata;
      end
      SETUP: begin
        state_d = ACCESS;
        penable_d = 1'b1;
        cnt_d = '0;
      end
      ACCESS: if (PREADY || (TIMEOUT != 0 && cnt_q == LAST)) begin
        state_d = RESP;
        psel_d = 1'b0;
        penable_d = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d = PREADY ? PSLVERR : 1'b1;
        rsp_rdata_d = PREADY && !pwrite_q ? PRDATA : '0;
      end else begin
        cnt_d = cnt_q == SAT ? cnt_q : cnt_q + 1'b1;
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign cmd_ready = state_q == IDLE && !PRESET;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err = rsp_err_q;
  assign PSELx = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE = pwrite_q;
  assign PADDR = paddr_q;
  assign PWDATA = pwdata_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed self-checking bench for apb_master_bridge
module tb_apb_master_bridge;
  logic PCLK = 1'b0, PRESET = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_err, PSELx, PENABLE, PWRITE, PREADY, PSLVERR = 1'b0, force_ready = 1'b0;
  logic [31:0] rsp_rdata, PADDR, PWDATA, PRDATA;
  logic [31:0] mem [16];
  int waits = 0, acc_cnt = 0, tests = 0, fails = 0;
  apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );
  always #5 PCLK = ~PCLK;
  assign PREADY = force_ready || (PSELx && PENABLE && acc_cnt >= waits);
  assign PRDATA = PADDR[3:0] == 4'd7 ? 32'h12345678 : mem[PADDR[3:0]];
  always @(posedge PCLK) begin
    acc_cnt <= (PSELx && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
    if (PSELx && PENABLE && PREADY && PWRITE) mem[PADDR[3:0]] <= PWDATA;
  end
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    tests++;
    if (!cmd_ready) begin fails++; $display("FAIL send_accept cmd_ready=%b required 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic test_reset();
    tests++; if ({PSELx, PENABLE, rsp_valid, cmd_ready, PADDR} !== 36'h0) begin fails++; $display("FAIL reset_vals got %h required 0", {PSELx, PENABLE, rsp_valid, cmd_ready, PADDR}); end
    PRESET = 1'b0;
    tick();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_release cmd_ready=%b required 1", cmd_ready); end
    waits = 1000;
    send(1'b0, 32'h4, 32'h0);
    tick();
    tests++; if (PENABLE !== 1'b1) begin fails++; $display("FAIL reset_in_access PENABLE=%b required 1", PENABLE); end
    PRESET = 1'b1;
    tick();
    tests++; if ({PSELx, PENABLE, rsp_valid, cmd_ready} !== 4'b0) begin fails++; $display("FAIL reset_mid psel/pen/rv/cr=%b required 0000", {PSELx, PENABLE, rsp_valid, cmd_ready}); end
    PRESET = 1'b0; waits = 0;
    tick();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_idle cmd_ready=%b required 1", cmd_ready); end
  endtask
  task automatic test_zero_wait();
    send(1'b1, 32'h3, 32'hDEADBEEF);
    tests++; if ({PSELx, PENABLE, PWRITE, cmd_ready} !== 4'b1010 || PADDR !== 32'h3 || PWDATA !== 32'hDEADBEEF) begin fails++; $display("FAIL zw_setup sel/en/wr/cr=%b addr=%h wdata=%h required 1010 3 deadbeef", {PSELx, PENABLE, PWRITE, cmd_ready}, PADDR, PWDATA); end
    tick();
    tests++; if ({PSELx, PENABLE, rsp_valid} !== 3'b110) begin fails++; $display("FAIL zw_access sel/en/rv=%b required 110", {PSELx, PENABLE, rsp_valid}); end
    tick();
    tests++; if ({PSELx, PENABLE, rsp_valid, rsp_err} !== 4'b0010 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL zw_wr_rsp sel/en/rv/err=%b rdata=%h required 0010 0", {PSELx, PENABLE, rsp_valid, rsp_err}, rsp_rdata); end
    tick();
    tests++; if ({cmd_ready, rsp_valid, PADDR} !== {2'b10, 32'h3}) begin fails++; $display("FAIL zw_idle cr/rv=%b addr=%h required 10 3", {cmd_ready, rsp_valid}, PADDR); end
    send(1'b0, 32'h3, 32'h0);
    tick(); tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL zw_rd_rsp rv=%b err=%b rdata=%h required 1 0 deadbeef", rsp_valid, rsp_err, rsp_rdata); end
    tick();
  endtask
  task automatic test_wait_states();
    waits = 3;
    send(1'b0, 32'h7, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if ({PSELx, PENABLE, PWRITE, rsp_valid} !== 4'b1100 || PADDR !== 32'h7) begin fails++; $display("FAIL ws_access%0d sel/en/wr/rv=%b addr=%h required 1100 7", i, {PSELx, PENABLE, PWRITE, rsp_valid}, PADDR); end
    end
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h12345678 || PENABLE !== 1'b0) begin fails++; $display("FAIL ws_rsp rv=%b err=%b rdata=%h en=%b required 1 0 12345678 0", rsp_valid, rsp_err, rsp_rdata, PENABLE); end
    tick();
    waits = 0;
  endtask
  task automatic test_error();
    PSLVERR = 1'b1;
    send(1'b1, 32'h5, 32'h55);
    tick(); tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL err_rsp rv=%b err=%b rdata=%h required 1 1 0", rsp_valid, rsp_err, rsp_rdata); end
    tick();
    force_ready = 1'b1;
    send(1'b0, 32'h3, 32'h0);
    tests++; if ({PSELx, PENABLE} !== 2'b10) begin fails++; $display("FAIL err_setup sel/en=%b required 10", {PSELx, PENABLE}); end
    tick();
    PSLVERR = 1'b0; force_ready = 1'b0;
    tests++; if ({PENABLE, rsp_valid} !== 2'b10) begin fails++; $display("FAIL err_ignore_ready en/rv=%b required 10", {PENABLE, rsp_valid}); end
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL err_outside rv=%b err=%b rdata=%h required 1 0 deadbeef", rsp_valid, rsp_err, rsp_rdata); end
    tick();
  endtask
  task automatic test_timeout();
    waits = 1000;
    send(1'b0, 32'h9, 32'h0);
    for (int i = 0; i < 16; i++) tick();
    tests++; if ({PENABLE, rsp_valid} !== 2'b10) begin fails++; $display("FAIL to_before en/rv=%b required 10", {PENABLE, rsp_valid}); end
    tick();
    tests++; if ({PSELx, PENABLE, rsp_valid, rsp_err} !== 4'b0011 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL to_abort sel/en/rv/err=%b rdata=%h required 0011 0", {PSELx, PENABLE, rsp_valid, rsp_err}, rsp_rdata); end
    tick();
    waits = 15; PSLVERR = 1'b1;
    send(1'b0, 32'h7, 32'h0);
    for (int i = 0; i < 17; i++) tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h12345678) begin fails++; $display("FAIL to_race rv=%b err=%b rdata=%h required 1 1 12345678", rsp_valid, rsp_err, rsp_rdata); end
    PSLVERR = 1'b0; waits = 0;
    tick();
  endtask
  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    send(1'b1, 32'h2, 32'hA5A5);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h2; cmd_wdata = 32'h0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tests++; if ({rsp_valid, rsp_err, cmd_ready, PSELx} !== 4'b1000 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL bp_hold%0d rv/err/cr/sel=%b rdata=%h required 1000 0", i, {rsp_valid, rsp_err, cmd_ready, PSELx}, rsp_rdata); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    tests++; if ({cmd_ready, rsp_valid, PSELx} !== 3'b100) begin fails++; $display("FAIL bp_idle cr/rv/sel=%b required 100", {cmd_ready, rsp_valid, PSELx}); end
    tick();
    cmd_valid = 1'b0;
    tests++; if ({PSELx, PENABLE, PWRITE, cmd_ready} !== 4'b1000 || PADDR !== 32'h2) begin fails++; $display("FAIL bp_accept sel/en/wr/cr=%b addr=%h required 1000 2", {PSELx, PENABLE, PWRITE, cmd_ready}, PADDR); end
    tick(); tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5) begin fails++; $display("FAIL bp_rd rv=%b rdata=%h required 1 a5a5", rsp_valid, rsp_rdata); end
    tick();
  endtask
  initial begin
    #1;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_error();
    test_timeout();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
